// File: rtl/memory_v.sv
// 64 x 20 synchronous ROM. Each word is i*i*i + i, fixed at elaboration.
// Read data is registered (block-RAM style), with an optional second output stage.
module memory_v #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 20,
    parameter bit          OUT_REG    = 1'b0
) (
    input  logic                  clka,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] douta
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rom [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Each word is an elaboration-time constant, so the read path is a plain table lookup.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam longint unsigned WORD = 64'(gi) * 64'(gi) * 64'(gi) + 64'(gi);
        assign rom[gi] = WORD[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rom[address];
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_q;

        always_ff @(posedge clka or negedge rst_n) begin
            if (!rst_n) begin
                out_q <= '0;
            end else begin
                out_q <= rd_q;
            end
        end

        assign douta = out_q;
    end else begin : g_no_out_reg
        assign douta = rd_q;
    end

endmodule

// File: tb/tb_memory_v.sv
// Directed-vector bench for memory_v: one instance without and one with the
// output register, both driven by the same clock, reset and address.
module tb_memory_v;

    logic        clk;
    logic        rst_n;
    logic [5:0]  address;
    logic [19:0] douta0;
    logic [19:0] douta1;

    int unsigned nvec;
    int unsigned nfail;

    typedef struct {
        logic [5:0]  addr;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs [17];

    memory_v #(.ADDR_WIDTH(6), .DATA_WIDTH(20), .OUT_REG(1'b0)) u_lat1 (
        .clka    (clk),
        .rst_n   (rst_n),
        .address (address),
        .douta   (douta0)
    );

    memory_v #(.ADDR_WIDTH(6), .DATA_WIDTH(20), .OUT_REG(1'b1)) u_lat2 (
        .clka    (clk),
        .rst_n   (rst_n),
        .address (address),
        .douta   (douta1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%05h), expected %0d (0x%05h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] a);
        @(negedge clk);
        address = a;
    endtask

    initial begin
        logic [19:0] prev;
        nvec  = 0;
        nfail = 0;

        vecs = '{
            '{6'd0,  20'd0},
            '{6'd1,  20'd2},
            '{6'd2,  20'd10},
            '{6'd3,  20'd30},
            '{6'd4,  20'd68},
            '{6'd5,  20'd130},
            '{6'd6,  20'd222},
            '{6'd2,  20'd10},
            '{6'd2,  20'd10},
            '{6'd2,  20'd10},
            '{6'd63, 20'd250110},
            '{6'd0,  20'd0},
            '{6'd10, 20'd1010},
            '{6'd31, 20'd29822},
            '{6'd32, 20'd32800},
            '{6'd47, 20'd103870},
            '{6'd15, 20'd3390}
        };

        // Reset held with the clock running: outputs stay at zero.
        rst_n   = 1'b0;
        address = 6'd5;
        #2;
        chk("reset_async_lat1", douta0, 20'd0);
        chk("reset_async_lat2", douta1, 20'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_hold_lat1", douta0, 20'd0);
            chk("reset_hold_lat2", douta1, 20'd0);
        end

        // First edge after release reads address 5.
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("release_lat1", douta0, 20'd130);
        chk("release_lat2", douta1, 20'd0);
        prev = 20'd130;

        // Table: lat1 shows this vector's word, lat2 shows the previous one.
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].addr);
            tick();
            chk($sformatf("vec%0d_lat1", i), douta0, vecs[i].exp);
            chk($sformatf("vec%0d_lat2", i), douta1, prev);
            prev = vecs[i].exp;
        end

        // Address change between edges must not reach douta.
        drive(6'd2);
        tick();
        chk("hold_pre_lat1", douta0, 20'd10);
        @(negedge clk);
        address = 6'd63;
        #2;
        chk("midcycle_addr_lat1", douta0, 20'd10);
        chk("midcycle_addr_lat2", douta1, 20'd3390);
        tick();
        chk("boundary63_lat1", douta0, 20'd250110);
        chk("boundary63_lat2", douta1, 20'd10);

        // Pipelined 1,2,3 stream.
        drive(6'd1);
        tick();
        drive(6'd2);
        tick();
        chk("pipe_a1_lat2", douta1, 20'd2);
        drive(6'd3);
        tick();
        chk("pipe_a2_lat2", douta1, 20'd10);
        tick();
        chk("pipe_a3_lat2", douta1, 20'd30);
        chk("pipe_a3_lat1", douta0, 20'd30);

        // Async reset between edges while outputs are nonzero, read in flight discarded.
        drive(6'd63);
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_async_lat1", douta0, 20'd0);
        chk("midreset_async_lat2", douta1, 20'd0);
        tick();
        chk("midreset_edge_lat1", douta0, 20'd0);
        chk("midreset_edge_lat2", douta1, 20'd0);

        @(negedge clk);
        rst_n   = 1'b1;
        address = 6'd4;
        tick();
        chk("post_reset_e1_lat1", douta0, 20'd68);
        chk("post_reset_e1_lat2", douta1, 20'd0);
        tick();
        chk("post_reset_e2_lat1", douta0, 20'd68);
        chk("post_reset_e2_lat2", douta1, 20'd68);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
